// File: rtl/freelist_fifo_mp_pkg.sv
// Shared rename-stage definitions: physical tag type, free-list sizing and the
// free-list pointer type stored by the BRAT. Optional bypass: FREELIST_BYPASS_EN.
`ifndef FREELIST_SIZE
`define FREELIST_SIZE 8
`endif
`ifndef SUPERSCALAR_WIDTH
`define SUPERSCALAR_WIDTH 2
`endif
`ifndef ARCH_REGFILE_SIZE
`define ARCH_REGFILE_SIZE 32
`endif

package freelist_fifo_mp_pkg;

  localparam int FREELIST_SIZE     = `FREELIST_SIZE;
  localparam int SUPERSCALAR_WIDTH = `SUPERSCALAR_WIDTH;
  localparam int ARCH_REGFILE_SIZE = `ARCH_REGFILE_SIZE;
  localparam int PHYS_REG_TAG_W    = $clog2(ARCH_REGFILE_SIZE + FREELIST_SIZE);

  typedef logic [PHYS_REG_TAG_W-1:0] PHYS_REG_TAG;

  // Head/tail pointer with wrap bit; the BRAT checkpoints values of this type.
  typedef logic [$clog2(FREELIST_SIZE):0] freelist_ptr_t;

endpackage

// File: rtl/freelist_fifo_mp_leading_ones.sv
// leading_ones_count: length of the run of set bits starting at lane 0.
module leading_ones_count
  import freelist_fifo_mp_pkg::*;
#(
  parameter  int WIDTH = SUPERSCALAR_WIDTH,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [CW-1:0]    o_count
);

  always_comb begin
    logic run;
    // NOTE: blocking assignments let the run flag ripple lane to lane in one evaluation.
    o_count = '0;
    run     = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      run = run & i_vec[i];
      if (run) o_count = o_count + CW'(1);
    end
  end

endmodule

// File: rtl/freelist_fifo_mp.sv
// freelist_fifo_mp: multi-lane free-list FIFO with head checkpoint restore.
// Define FREELIST_BYPASS_EN to forward same-cycle enqueues to the dequeue lanes.
module freelist_fifo_mp
  import freelist_fifo_mp_pkg::*;
#(
  parameter  type DATA_TYPE  = PHYS_REG_TAG,
  parameter  int  FIFO_DEPTH = `FREELIST_SIZE,
  parameter  int  WIDTH      = `SUPERSCALAR_WIDTH,
  parameter  int  INIT_FULL  = 1,
  localparam int  PW         = $clog2(FIFO_DEPTH) + 1,
  localparam int  CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             checkpoint_enable,
  input  logic [PW-1:0]    checkpoint_head_ptr_in,
  input  logic [WIDTH-1:0] enqueue,
  input  DATA_TYPE         data_in [WIDTH],
  input  logic [WIDTH-1:0] dequeue,
  output DATA_TYPE         head_packets [WIDTH],
  output logic [WIDTH-1:0] head_valid,
  output logic [WIDTH-1:0] enqueue_ready,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic [PW-1:0]    checkpoint_head_ptr_out
);

  localparam int IW  = PW - 1;
  localparam int LW  = $clog2(WIDTH + 1);
  localparam int LIW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW  = $bits(DATA_TYPE);

  DATA_TYPE      r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;

  logic [PW-1:0]    w_head_next;
  logic [LW-1:0]    w_n_enq_req;
  logic [LW-1:0]    w_n_deq_req;
  logic [LW-1:0]    w_n_enq;
  logic [WIDTH-1:0] w_wr_en;
  logic [IW-1:0]    w_wr_idx [WIDTH];

  leading_ones_count #(.WIDTH(WIDTH)) u_enq_run (
    .i_vec   (enqueue),
    .o_count (w_n_enq_req)
  );

  leading_ones_count #(.WIDTH(WIDTH)) u_deq_run (
    .i_vec   (dequeue),
    .o_count (w_n_deq_req)
  );

  // Wrap bit makes tail - head exact even when the buffer is completely full.
  assign count = CW'(r_tail - r_head);
  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign checkpoint_head_ptr_out = w_head_next;

  always_comb begin
    int space;
    int avail;
    int n_enq;
    int n_deq;
`ifdef FREELIST_BYPASS_EN
    int rel;
`endif
    space = FIFO_DEPTH - int'(count);
    n_enq = (int'(w_n_enq_req) < space) ? int'(w_n_enq_req) : space;
`ifdef FREELIST_BYPASS_EN
    avail = int'(count) + n_enq;
`else
    avail = int'(count);
`endif
    n_deq = (int'(w_n_deq_req) < avail) ? int'(w_n_deq_req) : avail;

    w_n_enq     = LW'(n_enq);
    w_head_next = checkpoint_enable ? checkpoint_head_ptr_in : r_head + PW'(n_deq);

    for (int i = 0; i < WIDTH; i++) begin
      enqueue_ready[i] = (i < space);
      head_valid[i]    = (i < avail);
      w_wr_en[i]       = (i < n_enq);
      w_wr_idx[i]      = r_tail[IW-1:0] + IW'(i);
      head_packets[i]  = r_mem[r_head[IW-1:0] + IW'(i)];
`ifdef FREELIST_BYPASS_EN
      // Lanes past the stored entries forward this cycle's enqueue data.
      rel = i - int'(count);
      if (rel >= 0 && rel < n_enq) head_packets[i] = data_in[LIW'(rel)];
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the storage array is reset on purpose: the free list must come up
      // holding every physical tag above the architectural ones.
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        r_mem[IW'(k)] <= DW'(k + ARCH_REGFILE_SIZE);
      end
      r_head <= '0;
      r_tail <= (INIT_FULL != 0) ? PW'(FIFO_DEPTH) : '0;
    end else begin
      for (int j = 0; j < WIDTH; j++) begin
        if (w_wr_en[j]) r_mem[w_wr_idx[j]] <= data_in[LIW'(j)];
      end
      r_head <= w_head_next;
      r_tail <= r_tail + PW'(w_n_enq);
    end
  end

endmodule

// File: tb/tb_freelist_fifo_mp.sv
// Self-checking bench for freelist_fifo_mp (depth 8, 2 lanes, reset full) with a
// pointer-arithmetic reference model; honours FREELIST_BYPASS_EN.
module tb_freelist_fifo_mp;
  import freelist_fifo_mp_pkg::*;

  localparam int D    = 8;
  localparam int W    = 2;
  localparam int PW   = 4;
  localparam int CW   = 4;
  localparam int ARCH = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          checkpoint_enable;
  logic [PW-1:0] checkpoint_head_ptr_in;
  logic [W-1:0]  enqueue;
  PHYS_REG_TAG   data_in [W];
  logic [W-1:0]  dequeue;
  PHYS_REG_TAG   head_packets [W];
  logic [W-1:0]  head_valid;
  logic [W-1:0]  enqueue_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic [PW-1:0] checkpoint_head_ptr_out;

  freelist_fifo_mp #(
    .DATA_TYPE  (PHYS_REG_TAG),
    .FIFO_DEPTH (D),
    .WIDTH      (W),
    .INIT_FULL  (1)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .checkpoint_enable       (checkpoint_enable),
    .checkpoint_head_ptr_in  (checkpoint_head_ptr_in),
    .enqueue                 (enqueue),
    .data_in                 (data_in),
    .dequeue                 (dequeue),
    .head_packets            (head_packets),
    .head_valid              (head_valid),
    .enqueue_ready           (enqueue_ready),
    .count                   (count),
    .full                    (full),
    .empty                   (empty),
    .checkpoint_head_ptr_out (checkpoint_head_ptr_out)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: storage contents plus head/tail as 4-bit wrapping counters.
  int m_mem [D];
  int m_head;
  int m_tail;
  int obs_ckpt;
  int exp_ckpt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lead_run(input logic [1:0] v);
    return (v == 2'b11) ? 2 : ((v == 2'b01) ? 1 : 0);
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic drive_idle();
    checkpoint_enable      = 1'b0;
    checkpoint_head_ptr_in = '0;
    enqueue                = '0;
    dequeue                = '0;
    data_in[0]             = '0;
    data_in[1]             = '0;
  endtask

  // Reset is held for one edge while enqueue, dequeue and checkpoint are all asserted.
  task automatic do_reset();
    @(negedge clock);
    reset                  = 1'b1;
    enqueue                = 2'b11;
    dequeue                = 2'b11;
    checkpoint_enable      = 1'b1;
    checkpoint_head_ptr_in = 4'd5;
    data_in[0]             = 6'd1;
    data_in[1]             = 6'd2;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    drive_idle();
    for (int i = 0; i < D; i++) m_mem[i] = i + ARCH;
    m_head = 0;
    m_tail = D;
  endtask

  // One cycle: drive at negedge, compare all outputs 1 ns later, then commit the model.
  task automatic step(input logic [1:0] enq, input int d0, input int d1,
                      input logic [1:0] deq, input logic cken, input int ck);
    int cnt, space, n_enq, avail, n_deq, head_next, exp_pkt;
    int din [W];
    logic [W-1:0] exp_ready, exp_valid;
    @(negedge clock);
    enqueue                = enq;
    dequeue                = deq;
    data_in[0]             = PHYS_REG_TAG'(d0);
    data_in[1]             = PHYS_REG_TAG'(d1);
    checkpoint_enable      = cken;
    checkpoint_head_ptr_in = PW'(ck);
    din[0] = d0;
    din[1] = d1;
    #1;
    cnt   = (m_tail - m_head) & 15;
    space = D - cnt;
    n_enq = min2(lead_run(enq), space);
`ifdef FREELIST_BYPASS_EN
    avail = cnt + n_enq;
`else
    avail = cnt;
`endif
    n_deq     = cken ? 0 : min2(lead_run(deq), avail);
    head_next = cken ? (ck & 15) : ((m_head + n_deq) & 15);
    for (int i = 0; i < W; i++) begin
      exp_ready[i] = (i < space);
      exp_valid[i] = (i < avail);
    end
    check("count", count, cnt);
    check("full", full, cnt == D);
    check("empty", empty, cnt == 0);
    check("enqueue_ready", enqueue_ready, exp_ready);
    check("head_valid", head_valid, exp_valid);
    check("ckpt_head_ptr_out", checkpoint_head_ptr_out, head_next);
    for (int i = 0; i < W; i++) begin
      if (i < avail) begin
        exp_pkt = (i < cnt) ? m_mem[(m_head + i) % D] : din[i - cnt];
        check($sformatf("head_packets[%0d]", i), head_packets[i], exp_pkt);
      end
    end
    obs_ckpt = int'(checkpoint_head_ptr_out);
    exp_ckpt = head_next;
    for (int j = 0; j < n_enq; j++) m_mem[(m_tail + j) % D] = din[j];
    m_tail = (m_tail + n_enq) & 15;
    m_head = head_next;
    @(posedge clock);
  endtask

  initial begin
    int saved;
    int saved_ok;
    reset = 1'b0;
    drive_idle();

    // Reset full, with competing inputs asserted during reset.
    do_reset();
    #1;
    check("reset_count", count, 8);
    check("reset_full", full, 1);
    check("reset_valid", head_valid, 2'b11);
    check("reset_ready", enqueue_ready, 2'b00);
    check("reset_pkt0", head_packets[0], 32);
    check("reset_pkt1", head_packets[1], 33);

    // Dual dequeue drains tags 32..39, then the FIFO reports empty.
    for (int c = 0; c < 4; c++) step(2'b00, 0, 0, 2'b11, 1'b0, 0);
    step(2'b00, 0, 0, 2'b00, 1'b0, 0);
    check("drained_empty", empty, 1);
    check("drained_valid", head_valid, 2'b00);

    // Move both pointers to index 6, then straddle the wrap point.
    for (int c = 0; c < 3; c++) step(2'b11, 10 + c, 20 + c, 2'b00, 1'b0, 0);
    for (int c = 0; c < 3; c++) step(2'b00, 0, 0, 2'b11, 1'b0, 0);
    step(2'b11, 4, 5, 2'b00, 1'b0, 0);
    step(2'b11, 6, 7, 2'b00, 1'b0, 0);
    step(2'b00, 0, 0, 2'b11, 1'b0, 0);
    step(2'b00, 0, 0, 2'b11, 1'b0, 0);

    // Prefix rule: a hole at lane 0 blocks both sides.
    step(2'b11, 50, 51, 2'b00, 1'b0, 0);
    step(2'b10, 52, 53, 2'b00, 1'b0, 0);
    step(2'b00, 0, 0, 2'b10, 1'b0, 0);
    step(2'b00, 0, 0, 2'b00, 1'b0, 0);
    check("prefix_count", count, 2);

    // Checkpoint capture and restore with a simultaneous dual dequeue.
    do_reset();
    step(2'b00, 0, 0, 2'b11, 1'b0, 0);
    check("ckpt_capture", obs_ckpt, 2);
    saved = obs_ckpt;
    step(2'b00, 0, 0, 2'b11, 1'b0, 0);
    step(2'b00, 0, 0, 2'b11, 1'b0, 0);
    step(2'b00, 0, 0, 2'b11, 1'b1, saved);
    step(2'b00, 0, 0, 2'b00, 1'b0, 0);
    #1;
    check("ckpt_count", count, 6);
    check("ckpt_pkt0", head_packets[0], 34);
    check("ckpt_pkt1", head_packets[1], 35);

    // Enqueue-and-dequeue into an empty FIFO.
    do_reset();
    for (int c = 0; c < 4; c++) step(2'b00, 0, 0, 2'b11, 1'b0, 0);
    step(2'b01, 40, 0, 2'b01, 1'b0, 0);
    #1;
`ifdef FREELIST_BYPASS_EN
    check("bypass_count", count, 0);
`else
    check("no_bypass_count", count, 1);
    check("no_bypass_pkt0", head_packets[0], 40);
`endif

    // Randomized traffic with occasional checkpoint capture/restore and resets.
    saved_ok = 0;
    saved    = 0;
    for (int c = 0; c < 400; c++) begin
      logic [1:0] enq_v, deq_v;
      logic       ck_en;
      enq_v = 2'($urandom_range(3));
      deq_v = 2'($urandom_range(3));
      ck_en = 1'b0;
      if (saved_ok != 0 && $urandom_range(9) == 0 && ((m_tail - saved) & 15) <= D - W) ck_en = 1'b1;
      if ($urandom_range(99) == 0) begin
        do_reset();
        saved_ok = 0;
      end else begin
        step(enq_v, int'($urandom_range(63)), int'($urandom_range(63)), deq_v, ck_en, saved);
        if ($urandom_range(7) == 0) begin
          saved    = exp_ckpt;
          saved_ok = 1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
